// File: rtl/i2c_sched_pkg.sv
// Shared types for the I2C bus scheduler: engine commands, FSM states, requesters.
package i2c_sched_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_STOP  = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_START, S_ADDR, S_DATA, S_READ, S_STOP, S_FINISH
    } state_t;

    typedef enum logic {
        REQ_POLL  = 1'b0,
        REQ_WRITE = 1'b1
    } req_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic logic is_cmd_state(input state_t s);
        return s inside {S_START, S_ADDR, S_DATA, S_READ, S_STOP};
    endfunction

endpackage

// File: rtl/i2c_poll_timer.sv
// Switch poll tick generator: sets poll_pend every POLL_DIV cycles and counts ticks dropped while pending.
module i2c_poll_timer #(
    parameter int POLL_DIV = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    output logic       poll_pend,
    output logic [7:0] overrun_cnt
);
    localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= CW'(POLL_DIV - 1);
            poll_pend   <= 1'b0;
            overrun_cnt <= 8'h00;
        end else begin
            cnt <= tick ? CW'(POLL_DIV - 1) : cnt - CW'(1);
            // a tick coinciding with the grant re-arms the request rather than counting as dropped
            if (tick) begin
                poll_pend <= 1'b1;
                if (poll_pend && !clr && overrun_cnt != 8'hFF)
                    overrun_cnt <= overrun_cnt + 8'd1;
            end else if (clr) begin
                poll_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_scheduler.sv
// Round-robin sequencer sharing one byte-level I2C master between switch polling and host writes.
// Optional m_done watchdog enabled by defining I2C_SCHED_TIMEOUT_EN.
//   IDLE/ARB : wait for request / pick requester      START/ADDR/DATA/READ/STOP : issue one engine command
//   FINISH   : report result for one cycle, back to IDLE
module i2c_bus_scheduler
    import i2c_sched_pkg::*;
#(
    parameter int         CLK_HZ  = 100_000_000,
    parameter int         POLL_HZ = 100,
    parameter logic [6:0] SW_ADDR = 7'h57
`ifdef I2C_SCHED_TIMEOUT_EN
    , parameter int       TIMEOUT_CYC = 200_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       wr_done,
    output logic       wr_err,
    output logic [7:0] sw_value,
    output logic       sw_valid,
    output logic       poll_err,
    output logic [7:0] overrun_cnt,
    output logic       busy,
    output logic       m_cmd_valid,
    output logic [1:0] m_cmd,
    output logic [7:0] m_tx_data,
    output logic       m_rd_nack,
    input  logic       m_cmd_ready,
    input  logic       m_done,
    input  logic       m_ack,
    input  logic [7:0] m_rx_data
);
    localparam int POLL_DIV = CLK_HZ / POLL_HZ;

    state_t     state, state_nx;
    req_t       cur_req, last_grant;
    logic       waiting, err_q, err_set;
    logic [6:0] addr_q;
    logic [7:0] data_q, rx_q;
    logic       poll_pend, grant_poll, grant_wr;
    logic       cmd_fire, done_ev, tmo_ev;

    i2c_poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clr         (grant_poll),
        .poll_pend   (poll_pend),
        .overrun_cnt (overrun_cnt)
    );

    assign cmd_fire  = m_cmd_valid & m_cmd_ready;
    assign done_ev   = waiting & m_done;
    assign wr_ack    = grant_wr;
    assign busy      = !(state inside {S_IDLE, S_ARB});
    assign m_rd_nack = (state == S_READ);

`ifdef I2C_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (cmd_fire)
            tmo_cnt <= TW'(TIMEOUT_CYC - 1);
        else if (waiting && !m_done && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - TW'(1);
    end

    assign tmo_ev = waiting && !m_done && (tmo_cnt == '0);
`else
    assign tmo_ev = 1'b0;
`endif

    always_comb begin
        grant_poll = 1'b0;
        grant_wr   = 1'b0;
        if (state == S_ARB) begin
            if (poll_pend && wr_req) begin
                grant_poll = (last_grant == REQ_WRITE);
                grant_wr   = (last_grant == REQ_POLL);
            end else begin
                grant_poll = poll_pend;
                grant_wr   = wr_req;
            end
        end
    end

    always_comb begin
        state_nx = state;
        err_set  = tmo_ev | (done_ev & !m_ack & (state inside {S_ADDR, S_DATA}));
        case (state)
            S_IDLE:   if (poll_pend || wr_req) state_nx = S_ARB;
            S_ARB:    state_nx = (grant_poll || grant_wr) ? S_START : S_IDLE;
            S_START:  if (tmo_ev) state_nx = S_STOP;
                      else if (done_ev) state_nx = S_ADDR;
            S_ADDR:   if (tmo_ev || (done_ev && !m_ack)) state_nx = S_STOP;
                      else if (done_ev) state_nx = (cur_req == REQ_POLL) ? S_READ : S_DATA;
            S_DATA,
            S_READ:   if (tmo_ev || done_ev) state_nx = S_STOP;
            S_STOP:   if (tmo_ev || done_ev) state_nx = S_FINISH;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        m_cmd     = CMD_START;
        m_tx_data = 8'h00;
        case (state)
            S_ADDR: begin
                m_cmd     = CMD_WRITE;
                m_tx_data = (cur_req == REQ_POLL) ? {SW_ADDR, RW_READ} : {addr_q, RW_WRITE};
            end
            S_DATA: begin
                m_cmd     = CMD_WRITE;
                m_tx_data = data_q;
            end
            S_READ:  m_cmd = CMD_READ;
            S_STOP:  m_cmd = CMD_STOP;
            default: m_cmd = CMD_START;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_req     <= REQ_POLL;
            last_grant  <= REQ_WRITE;
            waiting     <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= 7'h00;
            data_q      <= 8'h00;
            rx_q        <= 8'h00;
            m_cmd_valid <= 1'b0;
            sw_value    <= 8'h00;
            sw_valid    <= 1'b0;
            poll_err    <= 1'b0;
            wr_done     <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            state    <= state_nx;
            sw_valid <= 1'b0;
            wr_done  <= 1'b0;
            wr_err   <= 1'b0;

            if (grant_poll) begin
                cur_req    <= REQ_POLL;
                last_grant <= REQ_POLL;
                err_q      <= 1'b0;
            end else if (grant_wr) begin
                cur_req    <= REQ_WRITE;
                last_grant <= REQ_WRITE;
                addr_q     <= wr_addr;
                data_q     <= wr_data;
                err_q      <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end

            // valid rises on entry to each command state and falls at the handshake
            if (state_nx != state && is_cmd_state(state_nx))
                m_cmd_valid <= 1'b1;
            else if (cmd_fire)
                m_cmd_valid <= 1'b0;

            if (cmd_fire)
                waiting <= 1'b1;
            else if (done_ev || tmo_ev)
                waiting <= 1'b0;

            if (state == S_READ && done_ev)
                rx_q <= m_rx_data;

            if (state == S_FINISH) begin
                if (cur_req == REQ_POLL) begin
                    poll_err <= err_q;
                    if (!err_q) begin
                        sw_value <= rx_q;
                        sw_valid <= 1'b1;
                    end
                end else begin
                    wr_done <= 1'b1;
                    wr_err  <= err_q;
                end
            end
        end
    end

endmodule
